ram_fifo_ctrl: RTL and testbench

//   Push/pop FIFO controller that drives the ram_256x16 dual-port RAM.

---
 rtl/ram_fifo_ctrl_pkg.sv | 15 +
 rtl/ram_fifo_ctrl.sv | 93 +++++++++
 tb/tb_ram_fifo_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared sizing constants and flag payload for the RAM-backed FIFO controller.
package ram_fifo_ctrl_pkg;

  localparam int unsigned FIFO_DATA_W       = 16;
  localparam int unsigned FIFO_ADDR_W       = 8;
  localparam int unsigned FIFO_DEPTH        = 1 << FIFO_ADDR_W;
  localparam int unsigned FIFO_AFULL_THRESH = 240;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
  } fifo_flags_t;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// Push/pop controller that turns a registered-read dual-port RAM into a synchronous FIFO.
// Owns pointers, occupancy, status flags and the read-valid strobe; the RAM lives in the parent.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W       = FIFO_DATA_W,
  parameter int unsigned ADDR_W       = FIFO_ADDR_W,
  parameter int unsigned AFULL_THRESH = FIFO_AFULL_THRESH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic [ADDR_W-1:0] ram_read_addr,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_nxt;
  fifo_flags_t       flags_q;
  fifo_flags_t       flags_nxt;
  logic              pop_acc;
  logic              push_acc;
  logic              dout_valid_q;
  logic              overflow_q;
  logic              underflow_q;

  // Accept decisions and next occupancy; a pop frees the slot a full-FIFO push needs.
  always_comb begin
    pop_acc               = pop & ~flags_q.empty;
    push_acc              = push & (~flags_q.full | pop_acc);
    count_nxt             = count_q + CNT_W'(push_acc) - CNT_W'(pop_acc);
    flags_nxt.full        = (count_nxt == CNT_W'(DEPTH));
    flags_nxt.empty       = (count_nxt == '0);
    flags_nxt.almost_full = (count_nxt >= CNT_W'(AFULL_THRESH));
  end

  // Flags are registered from the next count so they track the count register exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count_q           <= '0;
      flags_q.full      <= 1'b0;
      flags_q.empty     <= 1'b1;
      flags_q.almost_full <= 1'b0;
      dout_valid_q      <= 1'b0;
      overflow_q        <= 1'b0;
      underflow_q       <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + ADDR_W'(1);
      count_q      <= count_nxt;
      flags_q      <= flags_nxt;
      dout_valid_q <= pop_acc;
      overflow_q   <= overflow_q | (push & flags_q.full & ~pop_acc);
      underflow_q  <= underflow_q | (pop & flags_q.empty);
    end
  end

  // RAM drive is combinational so the write and read land on the accepting edge.
  assign ram_we         = push_acc;
  assign ram_write_addr = wr_ptr;
  assign ram_din        = din;
  assign ram_read_addr  = rd_ptr;

  assign dout        = ram_dout;
  assign dout_valid  = dout_valid_q;
  assign full        = flags_q.full;
  assign empty       = flags_q.empty;
  assign almost_full = flags_q.almost_full;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a registered-read 256x16 RAM model alongside.
module tb_ram_fifo_ctrl;

  logic        clk;
  logic        rst_n;
  logic        push;
  logic [15:0] din;
  logic        pop;
  logic [15:0] dout;
  logic        dout_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic [8:0]  count;
  logic        overflow;
  logic        underflow;
  logic        ram_we;
  logic [7:0]  ram_write_addr;
  logic [15:0] ram_din;
  logic [7:0]  ram_read_addr;
  logic [15:0] ram_dout;

  logic [15:0] mem [256];

  int          n_vec;
  int          n_err;
  logic [15:0] model_q [$];
  logic [15:0] exp_q [$];
  logic [7:0]  m_wr;
  logic [7:0]  m_rd;

  ram_fifo_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .push           (push),
    .din            (din),
    .pop            (pop),
    .dout           (dout),
    .dout_valid     (dout_valid),
    .full           (full),
    .empty          (empty),
    .almost_full    (almost_full),
    .count          (count),
    .overflow       (overflow),
    .underflow      (underflow),
    .ram_we         (ram_we),
    .ram_write_addr (ram_write_addr),
    .ram_din        (ram_din),
    .ram_read_addr  (ram_read_addr),
    .ram_dout       (ram_dout)
  );

  // Registered-read dual-port RAM, same behaviour as ram_256x16.
  always @(posedge clk) begin
    if (ram_we) mem[ram_write_addr] <= ram_din;
    ram_dout <= mem[ram_read_addr];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid word must be the next one the scoreboard expects.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_dout_valid", 32'(dout_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("dout_order", 32'(dout), 32'(e));
        end
      end
    end
  end

  // One clock of stimulus; the model decides acceptance and queues expected read data.
  task automatic drive(input logic p, input logic [15:0] d, input logic q);
    logic pop_ok;
    logic push_ok;
    push = p;
    din  = d;
    pop  = q;
    #1;
    pop_ok  = q && (model_q.size() > 0);
    push_ok = p && ((model_q.size() < 256) || pop_ok);
    chk("ram_we", 32'(ram_we), 32'(push_ok));
    chk("ram_read_addr", 32'(ram_read_addr), 32'(m_rd));
    if (push_ok) begin
      chk("ram_write_addr", 32'(ram_write_addr), 32'(m_wr));
      chk("ram_din", 32'(ram_din), 32'(d));
    end
    if (pop_ok) begin
      exp_q.push_back(model_q.pop_front());
      m_rd = m_rd + 8'd1;
    end
    if (push_ok) begin
      model_q.push_back(d);
      m_wr = m_wr + 8'd1;
    end
    step();
    push = 1'b0;
    pop  = 1'b0;
    chk("count", 32'(count), 32'(model_q.size()));
    chk("empty", 32'(empty), 32'(model_q.size() == 0));
    chk("full", 32'(full), 32'(model_q.size() == 256));
    chk("almost_full", 32'(almost_full), 32'(model_q.size() >= 240));
    chk("dout_valid", 32'(dout_valid), 32'(pop_ok));
  endtask

  initial begin
    int sent;
    n_vec = 0;
    n_err = 0;
    m_wr  = 8'd0;
    m_rd  = 8'd0;
    rst_n = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    din   = 16'h0;
    step();
    step();
    rst_n = 1'b1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_afull", 32'(almost_full), 32'd0);
    chk("reset_valid", 32'(dout_valid), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    chk("reset_unf", 32'(underflow), 32'd0);

    // 1: three pushes land at addresses 0,1,2
    drive(1'b1, 16'haaaa, 1'b0);
    drive(1'b1, 16'hbbbb, 1'b0);
    drive(1'b1, 16'hcccc, 1'b0);
    chk("t1_count", 32'(count), 32'd3);
    chk("t1_empty", 32'(empty), 32'd0);

    // 2: back-to-back pops return words one cycle later
    drive(1'b0, 16'h0, 1'b1);
    chk("t2_dout0", 32'(dout), 32'h aaaa);
    drive(1'b0, 16'h0, 1'b1);
    chk("t2_dout1", 32'(dout), 32'h bbbb);
    drive(1'b0, 16'h0, 1'b1);
    chk("t2_dout2", 32'(dout), 32'h cccc);
    chk("t2_count", 32'(count), 32'd0);
    chk("t2_empty", 32'(empty), 32'd1);

    // 3: fill to 256, threshold and full edges, then a rejected push
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 16'(16'h1000 + i), 1'b0);
      if (i == 238) chk("t3_afull_239", 32'(almost_full), 32'd0);
      if (i == 239) chk("t3_afull_240", 32'(almost_full), 32'd1);
      if (i == 254) chk("t3_full_255", 32'(full), 32'd0);
      if (i == 255) chk("t3_full_256", 32'(full), 32'd1);
    end
    chk("t3_ovf_before", 32'(overflow), 32'd0);
    drive(1'b1, 16'hdead, 1'b0);
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_count", 32'(count), 32'd256);

    // 4: full with push+pop accepts both; drain; then empty with push+pop
    drive(1'b1, 16'hbeef, 1'b1);
    chk("t4_full_count", 32'(count), 32'd256);
    for (int i = 0; i < 256; i++) drive(1'b0, 16'h0, 1'b1);
    chk("t4_drained", 32'(empty), 32'd1);
    chk("t4_unf_before", 32'(underflow), 32'd0);
    drive(1'b1, 16'h5a5a, 1'b1);
    chk("t4_empty_count", 32'(count), 32'd1);
    chk("t4_empty_valid", 32'(dout_valid), 32'd0);
    chk("t4_underflow", 32'(underflow), 32'd1);
    drive(1'b0, 16'h0, 1'b1);
    chk("t4_dout", 32'(dout), 32'h5a5a);

    // 5: 600-word stream in uneven bursts wraps both pointers
    sent = 0;
    while (sent < 600) begin
      for (int k = 0; k < 9 && sent < 600; k++) begin
        drive(1'b1, 16'(sent * 37 + 5), 1'b0);
        sent++;
      end
      for (int k = 0; k < 7 && model_q.size() > 0; k++) drive(1'b0, 16'h0, 1'b1);
    end
    while (model_q.size() > 0) drive(1'b0, 16'h0, 1'b1);
    chk("t5_empty", 32'(empty), 32'd1);

    // 6: reset with five entries and a pop at the same edge
    for (int i = 0; i < 5; i++) drive(1'b1, 16'(16'h7700 + i), 1'b0);
    chk("t6_count_pre", 32'(count), 32'd5);
    rst_n = 1'b0;
    pop   = 1'b1;
    step();
    rst_n = 1'b1;
    pop   = 1'b0;
    model_q.delete();
    m_wr  = 8'd0;
    m_rd  = 8'd0;
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_valid", 32'(dout_valid), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk("t6_unf", 32'(underflow), 32'd0);

    // Post-reset sanity: FIFO restarts from address 0
    drive(1'b1, 16'h1234, 1'b0);
    drive(1'b0, 16'h0, 1'b1);
    chk("t6_dout", 32'(dout), 32'h1234);
    drive(1'b0, 16'h0, 1'b0);
    drive(1'b0, 16'h0, 1'b0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
